// File: rtl/crc24_axis_checker.sv
// CRC-24 AXI-Stream receive checker.
// Holds the last three accepted bytes in a delay line so the trailing CRC can be
// stripped. Older bytes are recomputed into a running CRC and forwarded through a
// one-deep registered output stage. At the end of each frame the checker reports
// the CRC verdict on the last payload beat (m_tuser) and on a status pulse, and it
// updates saturating good/bad frame counters.
module crc24_axis_checker #(
  parameter logic [23:0] POLY  = 24'h864CFB,
  parameter logic [23:0] INIT  = 24'h000000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             stat_valid,
  output logic             stat_ok,
  output logic             stat_runt,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] bad_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Fold one byte into the CRC, MSB first, with no reflection.
  function automatic logic [23:0] crc24_byte(input logic [23:0] crc_in, input logic [7:0] b);
    logic [23:0] c;
    c = crc_in ^ {b, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      if (c[23]) begin
        c = (c << 1) ^ POLY;
      end else begin
        c = c << 1;
      end
    end
    return c;
  endfunction

  // Delay line: [23:16] oldest, [7:0] newest.
  logic [23:0]      dl_q, dl_d;
  logic [1:0]       fill_q, fill_d;
  logic [23:0]      crc_q, crc_d;
  logic [7:0]       m_tdata_q, m_tdata_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tlast_q, m_tlast_d;
  logic             m_tuser_q, m_tuser_d;
  logic             stat_valid_q, stat_valid_d;
  logic             stat_ok_q, stat_ok_d;
  logic             stat_runt_q, stat_runt_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  logic             accept_s;
  logic             full_s;
  logic [23:0]      crc_fold_s;
  logic [23:0]      rx_crc_s;
  logic             crc_match_s;

  // The output stage can take a new beat when it is empty or being drained.
  assign s_tready    = !m_tvalid_q || m_tready;
  assign accept_s    = s_tvalid && s_tready;
  assign full_s      = (fill_q == 2'd3);
  assign crc_fold_s  = crc24_byte(crc_q, dl_q[23:16]);
  assign rx_crc_s    = {dl_q[15:0], s_tdata};
  assign crc_match_s = (rx_crc_s == crc_fold_s);

  // Next-state for delay line, CRC, output stage and status.
  always_comb begin
    dl_d         = dl_q;
    fill_d       = fill_q;
    crc_d        = crc_q;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    m_tuser_d    = m_tuser_q;
    stat_valid_d = 1'b0;
    stat_ok_d    = stat_ok_q;
    stat_runt_d  = stat_runt_q;
    if (m_tready) begin
      m_tvalid_d = 1'b0;
    end else begin
      m_tvalid_d = m_tvalid_q;
    end

    if (accept_s) begin
      if (s_tlast) begin
        if (full_s) begin
          // Oldest byte is the last payload byte; the remaining three are the trailer.
          m_tdata_d    = dl_q[23:16];
          m_tvalid_d   = 1'b1;
          m_tlast_d    = 1'b1;
          m_tuser_d    = !crc_match_s;
          stat_valid_d = 1'b1;
          stat_ok_d    = crc_match_s;
          stat_runt_d  = 1'b0;
        end else begin
          // Too short to carry a trailer: report a runt and produce no beat.
          stat_valid_d = 1'b1;
          stat_ok_d    = 1'b0;
          stat_runt_d  = 1'b1;
        end
        dl_d   = 24'h000000;
        fill_d = 2'd0;
        crc_d  = INIT;
      end else begin
        if (full_s) begin
          m_tdata_d  = dl_q[23:16];
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tuser_d  = 1'b0;
          crc_d      = crc_fold_s;
        end else begin
          fill_d = fill_q + 2'd1;
        end
        dl_d = {dl_q[15:0], s_tdata};
      end
    end else begin
      dl_d = dl_q;
    end
  end

  // Saturating frame counters, advanced in the cycle the status pulse is high.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (stat_valid_q) begin
      if (stat_ok_q) begin
        if (good_q != CNT_MAX) begin
          good_d = good_q + CNT_ONE;
        end else begin
          good_d = good_q;
        end
      end else begin
        if (bad_q != CNT_MAX) begin
          bad_d = bad_q + CNT_ONE;
        end else begin
          bad_d = bad_q;
        end
      end
    end else begin
      good_d = good_q;
    end
  end

  // State registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q         <= 24'h000000;
      fill_q       <= 2'd0;
      crc_q        <= INIT;
      m_tdata_q    <= 8'h00;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tuser_q    <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_ok_q    <= 1'b0;
      stat_runt_q  <= 1'b0;
      good_q       <= {CNT_W{1'b0}};
      bad_q        <= {CNT_W{1'b0}};
    end else begin
      dl_q         <= dl_d;
      fill_q       <= fill_d;
      crc_q        <= crc_d;
      m_tdata_q    <= m_tdata_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tuser_q    <= m_tuser_d;
      stat_valid_q <= stat_valid_d;
      stat_ok_q    <= stat_ok_d;
      stat_runt_q  <= stat_runt_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_tvalid   = m_tvalid_q;
  assign m_tlast    = m_tlast_q;
  assign m_tuser    = m_tuser_q;
  assign stat_valid = stat_valid_q;
  assign stat_ok    = stat_ok_q;
  assign stat_runt  = stat_runt_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;

endmodule

// File: tb/tb_crc24_axis_checker.sv
// Directed bench for crc24_axis_checker: instance A uses INIT=0, instance B
// uses INIT=24'hB704CE. The sel input steers stimulus and monitoring to one.
module tb_crc24_axis_checker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       m_tready = 1'b1;
  logic       sel;
  logic       rand_en = 1'b0;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [9:0] beat_q[$];
  logic [1:0] stat_q[$];

  logic        a_s_tvalid, a_s_tready, a_m_tvalid, a_m_tlast, a_m_tuser;
  logic        a_stat_valid, a_stat_ok, a_stat_runt;
  logic [7:0]  a_m_tdata;
  logic [15:0] a_good, a_bad;
  logic        b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tlast, b_m_tuser;
  logic        b_stat_valid, b_stat_ok, b_stat_runt;
  logic [7:0]  b_m_tdata;
  logic [15:0] b_good, b_bad;

  always #5 clk = ~clk;

  assign a_s_tvalid = s_tvalid && !sel;
  assign b_s_tvalid = s_tvalid && sel;

  crc24_axis_checker #(.POLY(24'h864CFB), .INIT(24'h000000), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tlast(s_tlast),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(m_tready),
    .m_tlast(a_m_tlast), .m_tuser(a_m_tuser),
    .stat_valid(a_stat_valid), .stat_ok(a_stat_ok), .stat_runt(a_stat_runt),
    .good_count(a_good), .bad_count(a_bad)
  );

  crc24_axis_checker #(.POLY(24'h864CFB), .INIT(24'hB704CE), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tlast(s_tlast),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(m_tready),
    .m_tlast(b_m_tlast), .m_tuser(b_m_tuser),
    .stat_valid(b_stat_valid), .stat_ok(b_stat_ok), .stat_runt(b_stat_runt),
    .good_count(b_good), .bad_count(b_bad)
  );

  logic       cur_s_tready, cur_m_tvalid, cur_m_tlast, cur_m_tuser;
  logic       cur_stat_valid, cur_stat_ok, cur_stat_runt;
  logic [7:0] cur_m_tdata;

  assign cur_s_tready   = sel ? b_s_tready   : a_s_tready;
  assign cur_m_tvalid   = sel ? b_m_tvalid   : a_m_tvalid;
  assign cur_m_tlast    = sel ? b_m_tlast    : a_m_tlast;
  assign cur_m_tuser    = sel ? b_m_tuser    : a_m_tuser;
  assign cur_m_tdata    = sel ? b_m_tdata    : a_m_tdata;
  assign cur_stat_valid = sel ? b_stat_valid : a_stat_valid;
  assign cur_stat_ok    = sel ? b_stat_ok    : a_stat_ok;
  assign cur_stat_runt  = sel ? b_stat_runt  : a_stat_runt;

  // Downstream ready changes just after the rising edge, so it is stable at the falling edge.
  always @(posedge clk) begin
    #1;
    if (rand_en) m_tready = 1'($urandom_range(0, 1));
    else         m_tready = 1'b1;
  end

  // Record output beats, status pulses and handshake rule breaks of the selected instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (cur_m_tvalid && m_tready) beat_q.push_back({cur_m_tlast, cur_m_tuser, cur_m_tdata});
      if (cur_stat_valid) stat_q.push_back({cur_stat_ok, cur_stat_runt});
      if (cur_m_tvalid && !m_tready && cur_s_tready) viol++;
    end
  end

  // Present one byte from a falling edge and hold it until accepted.
  task automatic send(input logic [7:0] b, input logic last, input int gap);
    logic rdy;
    int   tries;
    s_tvalid = 1'b0;
    repeat (gap) @(negedge clk);
    s_tdata  = b;
    s_tlast  = last;
    s_tvalid = 1'b1;
    rdy = 1'b0;
    tries = 0;
    while (!rdy && tries < 200) begin
      rdy = cur_s_tready;
      @(posedge clk);
      @(negedge clk);
      tries++;
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%02h never accepted", b);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
    for (int i = 0; i < bytes.size(); i++)
      send(bytes[i], (i == bytes.size() - 1), gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic drain();
    rand_en = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic clear_logs();
    beat_q.delete();
    stat_q.delete();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    checks++;
    if ({a_m_tvalid, a_m_tdata, a_m_tlast, a_m_tuser, a_stat_valid, a_stat_ok, a_stat_runt, a_good, a_bad} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs got tvalid=%b tdata=%02h good=%0d bad=%0d expected all 0",
               a_m_tvalid, a_m_tdata, a_good, a_bad);
    end
    checks++;
    if (a_s_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready got %b expected 1", a_s_tready);
    end
  endtask

  task automatic test_good_frame();
    sel = 1'b0; clear_logs();
    send_frame('{8'h01, 8'h86, 8'h4C, 8'hFB}, 1'b0);
    drain();
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== {1'b1, 1'b0, 8'h01}) begin
      errors++; $display("FAIL good_beat got n=%0d first=%03h expected n=1 first=201", beat_q.size(), beat_q.size() ? beat_q[0] : 10'h0);
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 2'b10) begin
      errors++; $display("FAIL good_stat got n=%0d expected one pulse ok=1 runt=0", stat_q.size());
    end
    checks++;
    if (a_good !== 16'd1 || a_bad !== 16'd0) begin
      errors++; $display("FAIL good_counts got good=%0d bad=%0d expected 1/0", a_good, a_bad);
    end
  endtask

  task automatic test_bad_frame();
    sel = 1'b0; clear_logs();
    send_frame('{8'h01, 8'h86, 8'h4C, 8'hFA}, 1'b0);
    drain();
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== {1'b1, 1'b1, 8'h01}) begin
      errors++; $display("FAIL bad_beat got n=%0d first=%03h expected n=1 first=301", beat_q.size(), beat_q.size() ? beat_q[0] : 10'h0);
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 2'b00) begin
      errors++; $display("FAIL bad_stat got n=%0d expected one pulse ok=0 runt=0", stat_q.size());
    end
    checks++;
    if (a_good !== 16'd1 || a_bad !== 16'd1) begin
      errors++; $display("FAIL bad_counts got good=%0d bad=%0d expected 1/1", a_good, a_bad);
    end
  endtask

  task automatic test_runt();
    sel = 1'b0; clear_logs();
    send_frame('{8'h86, 8'h4C}, 1'b0);
    drain();
    checks++;
    if (beat_q.size() != 0) begin
      errors++; $display("FAIL runt_beats got %0d expected 0", beat_q.size());
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 2'b01) begin
      errors++; $display("FAIL runt_stat got n=%0d expected one pulse ok=0 runt=1", stat_q.size());
    end
    checks++;
    if (a_bad !== 16'd2) begin
      errors++; $display("FAIL runt_bad_count got %0d expected 2", a_bad);
    end
    clear_logs();
    send_frame('{8'h01, 8'h86, 8'h4C, 8'hFB}, 1'b0);
    drain();
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== {1'b1, 1'b0, 8'h01} || a_good !== 16'd2) begin
      errors++; $display("FAIL after_runt got n=%0d good=%0d expected n=1 good=2", beat_q.size(), a_good);
    end
  endtask

  task automatic check_string(input string tag, input logic [15:0] exp_good);
    checks++;
    if (beat_q.size() != 9) begin
      errors++; $display("FAIL %s_count got %0d expected 9", tag, beat_q.size());
    end
    for (int i = 0; i < 9 && i < beat_q.size(); i++) begin
      logic [9:0] exp;
      exp = {(i == 8), 1'b0, 8'h31 + 8'(i)};
      checks++;
      if (beat_q[i] !== exp) begin
        errors++; $display("FAIL %s_beat%0d got %03h expected %03h", tag, i, beat_q[i], exp);
      end
    end
    checks++;
    if (stat_q.size() != 1 || stat_q[0] !== 2'b10) begin
      errors++; $display("FAIL %s_stat got n=%0d expected one pulse ok=1", tag, stat_q.size());
    end
    checks++;
    if (b_good !== exp_good || b_bad !== 16'd0) begin
      errors++; $display("FAIL %s_counts got good=%0d bad=%0d expected %0d/0", tag, b_good, b_bad, exp_good);
    end
  endtask

  task automatic test_check_string();
    sel = 1'b1; clear_logs();
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h21, 8'hCF, 8'h02}, 1'b0);
    drain();
    check_string("string", 16'd1);
  endtask

  task automatic test_backpressure();
    sel = 1'b1; clear_logs();
    viol = 0;
    rand_en = 1'b1;
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h21, 8'hCF, 8'h02}, 1'b1);
    drain();
    check_string("bp", 16'd2);
    checks++;
    if (viol != 0) begin
      errors++; $display("FAIL bp_tready got %0d cycles with s_tready=1 while stalled expected 0", viol);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; clear_logs();
    send_frame('{8'h01, 8'h86, 8'h4C, 8'hFB}, 1'b0);
    send_frame('{8'h01, 8'h86, 8'h4C, 8'hFA}, 1'b0);
    drain();
    checks++;
    if (beat_q.size() != 2 || beat_q[0] !== {1'b1, 1'b0, 8'h01} || beat_q[1] !== {1'b1, 1'b1, 8'h01}) begin
      errors++; $display("FAIL b2b_beats got n=%0d expected 201 then 301", beat_q.size());
    end
    checks++;
    if (stat_q.size() != 2 || stat_q[0] !== 2'b10 || stat_q[1] !== 2'b00) begin
      errors++; $display("FAIL b2b_stat got n=%0d expected ok then bad", stat_q.size());
    end
    checks++;
    if (a_good !== 16'd3 || a_bad !== 16'd3) begin
      errors++; $display("FAIL b2b_counts got good=%0d bad=%0d expected 3/3", a_good, a_bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0; clear_logs();
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_m_tvalid, a_m_tdata, a_m_tlast, a_m_tuser, a_stat_valid, a_stat_ok, a_stat_runt, a_good, a_bad} !== 45'd0) begin
      errors++; $display("FAIL midreset_outputs got tvalid=%b good=%0d bad=%0d expected all 0", a_m_tvalid, a_good, a_bad);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_logs();
    send_frame('{8'h01, 8'h86, 8'h4C, 8'hFB}, 1'b0);
    drain();
    checks++;
    if (beat_q.size() != 1 || beat_q[0] !== {1'b1, 1'b0, 8'h01}) begin
      errors++; $display("FAIL midreset_beat got n=%0d expected one beat 201", beat_q.size());
    end
    checks++;
    if (a_good !== 16'd1 || a_bad !== 16'd0) begin
      errors++; $display("FAIL midreset_counts got good=%0d bad=%0d expected 1/0", a_good, a_bad);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_runt();
    test_check_string();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc24_axis_checker.md
Name: crc24_axis_checker

Overview:
- Receive-side companion to the byte-wide AXI-Stream CRC-24 generator; sits directly downstream of it, across the link.
- Consumes frames of payload bytes followed by a 3-byte CRC-24 trailer, with tlast on the final CRC byte.
- Recomputes the CRC over the payload and strips the trailer, forwarding payload-only frames downstream.
- Flags the CRC result on the last payload beat and on a status pulse, and keeps good/bad frame counters.

Parameters:
- POLY, 24'h864CFB, CRC-24 polynomial without the implicit x^24 term (matches the generator's 25-bit divisor).
- INIT, 24'h000000, CRC register value at the start of every frame; no reflection and no final XOR.
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_tdata  in  8  input byte (payload, then CRC bytes 23:16, 15:8, 7:0).
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted when s_tvalid && s_tready.
- s_tlast  in  1  marks the final CRC byte of a frame.
- m_tdata  out  8  payload byte.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  marks the last payload byte.
- m_tuser  out  1  CRC error flag; meaningful only when m_tlast=1.
- stat_valid  out  1  one-cycle pulse per completed input frame.
- stat_ok  out  1  CRC matched; valid with stat_valid.
- stat_runt  out  1  frame was shorter than 4 bytes; valid with stat_valid.
- good_count  out  CNT_W  saturating count of frames with a CRC match.
- bad_count  out  CNT_W  saturating count of CRC-mismatch and runt frames.

Behaviour:
- Reset (async, reset_n=0) forces all outputs to 0:
  - m_tvalid, m_tdata, m_tlast, m_tuser, stat_* and both counters are cleared.
  - The delay line is emptied, the fill count set to 0 and the CRC register set to INIT.
  - Reset mid-frame discards the partial frame; no status is produced for it.
- Handshake:
  - s_tready = !m_tvalid || m_tready (one-deep registered output stage).
  - m_tvalid holds with m_tdata/m_tlast/m_tuser stable until m_tready.
  - No combinational path from s_tvalid to m_tvalid.
- Delay line: 3-byte shift register with fill count 0..3 tracking the last 3 accepted bytes.
- Accepted non-last beat:
  - If fill<3: shift the byte in, fill+1, no output.
  - If fill==3: the oldest byte leaves as payload (m_tvalid=1 next cycle, m_tlast=0) and is folded into the CRC; the new byte shifts in.
- Accepted last beat with fill==3:
  - The oldest byte is emitted with m_tlast=1 and folded into the CRC.
  - The remaining two held bytes plus s_tdata form the received CRC, MSB first.
  - m_tuser = (received != computed CRC including that byte).
  - Next cycle: stat_valid=1, stat_ok=!m_tuser, stat_runt=0.
  - Fill is cleared to 0 and the CRC is reset to INIT.
- Accepted last beat with fill<3 (runt, fewer than 4 bytes):
  - No output beat.
  - Next cycle: stat_valid=1, stat_ok=0, stat_runt=1; bad_count increments.
  - Fill is cleared and the CRC is reset to INIT.
- CRC update per byte b:
  - c = crc ^ {b,16'h0}.
  - Repeat 8 times: c = c[23] ? ((c<<1) ^ POLY) : (c<<1), truncated to 24 bits.
- Counters:
  - good_count increments on stat_ok, bad_count on !stat_ok, in the cycle stat_valid is high.
  - Both hold at all-ones; they never wrap.
- Back-to-back frames: the first byte of the next frame may be accepted in the cycle after the tlast beat; frames never mix.
- Latency: payload byte k is output 1 cycle after byte k+3 is accepted; the last payload byte is output 1 cycle after the tlast beat.

Test Plan:
- INIT=0, input 01,86,4C,FB (tlast on FB) -> one output beat 01 with m_tlast=1, m_tuser=0; stat_valid with stat_ok=1; good_count=1.
- INIT=0, input 01,86,4C,FA -> output 01 with m_tlast=1, m_tuser=1; stat_ok=0; bad_count=1.
- INIT=24'hB704CE, input ASCII "123456789" then 21,CF,02 -> 9 payload beats, tlast on 0x39, m_tuser=0, stat_ok=1.
- Input 86,4C (tlast on 4C) -> no output; stat_runt=1, stat_ok=0, bad_count+1; the following valid frame still passes.
- Run test 3 with m_tready toggled randomly and s_tvalid gaps -> identical output sequence; s_tready=0 whenever m_tvalid && !m_tready.
- Assert reset_n low after the 5th byte of a frame -> all outputs 0 immediately; the next full frame passes with good_count=1.
